// File: rtl/layer_mixer_pkg.sv
// Shared definitions for the layer mixer: register map, reset values and
// the configuration register bundle used by the top level.
package layer_mixer_pkg;

    // Register addresses on the 5-bit register port
    localparam logic [4:0] ADDR_CTRL       = 5'd0;
    localparam logic [4:0] ADDR_BACKGROUND = 5'd1;
    localparam logic [4:0] ADDR_BORDER     = 5'd2;
    localparam logic [4:0] ADDR_HSTART_LO  = 5'd3;
    localparam logic [4:0] ADDR_HSTART_HI  = 5'd4;
    localparam logic [4:0] ADDR_HSTOP_LO   = 5'd5;
    localparam logic [4:0] ADDR_HSTOP_HI   = 5'd6;

    // Reset values
    localparam logic       CTRL_ENABLE_RST = 1'b1;
    localparam logic [7:0] BACKGROUND_RST  = 8'h00;
    localparam logic [7:0] BORDER_RST      = 8'h00;
    localparam logic [9:0] HSTART_RST      = 10'd0;
    localparam logic [9:0] HSTOP_DEFAULT   = 10'd640;

    // Highest line-buffer index; the x counter saturates here
    localparam logic [9:0] LB_IDX_MAX = 10'd1023;

    typedef struct packed {
        logic       enable;
        logic [7:0] background;
        logic [7:0] border;
        logic [9:0] hstart;
        logic [9:0] hstop;
    } mixer_cfg_t;

    localparam mixer_cfg_t CFG_RST = '{
        enable:     CTRL_ENABLE_RST,
        background: BACKGROUND_RST,
        border:     BORDER_RST,
        hstart:     HSTART_RST,
        hstop:      HSTOP_DEFAULT
    };

endpackage

// File: rtl/layer_mixer_prio.sv
// Combinational priority resolve: picks the topmost opaque source among the
// tile/bitmap layers and the sprite, falling back to the background colour.
module layer_mixer_prio
    import layer_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 8,
    parameter int ZW         = $clog2(NUM_LAYERS + 1)
) (
    input  logic [NUM_LAYERS-1:0]         layer_enabled,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
    input  logic                          sprite_enabled,
    input  logic [COLOR_W+ZW-1:0]         sprite_data,
    input  logic [COLOR_W-1:0]            background,
    output logic [COLOR_W-1:0]            pixel
);

    logic [COLOR_W-1:0] sprite_color;
    logic [ZW-1:0]      sprite_depth;
    logic               sprite_opaque;
    logic [31:0]        sprite_slot;

    assign sprite_color  = sprite_data[COLOR_W-1:0];
    assign sprite_depth  = sprite_data[COLOR_W +: ZW];
    // Depth 0 hides the sprite outright
    assign sprite_opaque = sprite_enabled && (sprite_color != '0) && (sprite_depth != '0);
    // Depths beyond the layer count put the sprite on top of everything
    assign sprite_slot   = (32'(sprite_depth) > 32'(NUM_LAYERS)) ? 32'(NUM_LAYERS)
                                                                 : 32'(sprite_depth);

    // Paint bottom to top; a later opaque source overwrites an earlier one.
    // The sprite at slot d is painted right after layer d-1.
    always_comb begin
        pixel = background;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (layer_enabled[i] && (layer_data[i*COLOR_W +: COLOR_W] != '0)) begin
                pixel = layer_data[i*COLOR_W +: COLOR_W];
            end
            if (sprite_opaque && (sprite_slot == 32'(i + 1))) begin
                pixel = sprite_color;
            end
        end
    end

endmodule

// File: rtl/layer_mixer.sv
// Layer mixer top: register file, line-buffer x counter, one-cycle index
// delay for window alignment and the registered output pixel.
module layer_mixer
    import layer_mixer_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int COLOR_W    = 8,
    parameter int ZW         = $clog2(NUM_LAYERS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    regs_addr,
    input  logic [7:0]                    regs_wrdata,
    input  logic                          regs_write,
    output logic [7:0]                    regs_rddata,
    input  logic [NUM_LAYERS-1:0]         layer_enabled,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_lb_data,
    input  logic                          sprite_enabled,
    input  logic [COLOR_W+ZW-1:0]         sprite_lb_data,
    output logic [9:0]                    lb_idx,
    output logic                          start_of_screen,
    output logic                          start_of_line,
    input  logic                          display_start_of_screen,
    input  logic                          display_start_of_line,
    input  logic                          display_next_pixel,
    output logic [COLOR_W-1:0]            display_data
);

    mixer_cfg_t         cfg;
    logic [9:0]         x_d1;
    logic               in_window;
    logic [COLOR_W-1:0] mixed;

    assign start_of_screen = display_start_of_screen;
    assign start_of_line   = display_start_of_line;

    // Register writes; unmapped addresses are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= CFG_RST;
        end else if (regs_write) begin
            case (regs_addr)
                ADDR_CTRL:       cfg.enable      <= regs_wrdata[0];
                ADDR_BACKGROUND: cfg.background  <= regs_wrdata;
                ADDR_BORDER:     cfg.border      <= regs_wrdata;
                ADDR_HSTART_LO:  cfg.hstart[7:0] <= regs_wrdata;
                ADDR_HSTART_HI:  cfg.hstart[9:8] <= regs_wrdata[1:0];
                ADDR_HSTOP_LO:   cfg.hstop[7:0]  <= regs_wrdata;
                ADDR_HSTOP_HI:   cfg.hstop[9:8]  <= regs_wrdata[1:0];
                default: ;
            endcase
        end
    end

    // Combinational read-back; unused bits and unmapped addresses read 0
    always_comb begin
        regs_rddata = 8'h00;
        case (regs_addr)
            ADDR_CTRL:       regs_rddata = {7'd0, cfg.enable};
            ADDR_BACKGROUND: regs_rddata = cfg.background;
            ADDR_BORDER:     regs_rddata = cfg.border;
            ADDR_HSTART_LO:  regs_rddata = cfg.hstart[7:0];
            ADDR_HSTART_HI:  regs_rddata = {6'd0, cfg.hstart[9:8]};
            ADDR_HSTOP_LO:   regs_rddata = cfg.hstop[7:0];
            ADDR_HSTOP_HI:   regs_rddata = {6'd0, cfg.hstop[9:8]};
            default:         regs_rddata = 8'h00;
        endcase
    end

    // x counter: start of line restarts it, next pixel advances it up to the last index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lb_idx <= '0;
        end else if (display_start_of_line) begin
            lb_idx <= '0;
        end else if (display_next_pixel && (lb_idx != LB_IDX_MAX)) begin
            lb_idx <= lb_idx + 10'd1;
        end
    end

    // Delay the index by one cycle so it lines up with the returned line-buffer data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_d1 <= '0;
        end else begin
            x_d1 <= lb_idx;
        end
    end

    layer_mixer_prio #(
        .NUM_LAYERS (NUM_LAYERS),
        .COLOR_W    (COLOR_W),
        .ZW         (ZW)
    ) u_prio (
        .layer_enabled  (layer_enabled),
        .layer_data     (layer_lb_data),
        .sprite_enabled (sprite_enabled),
        .sprite_data    (sprite_lb_data),
        .background     (COLOR_W'(cfg.background)),
        .pixel          (mixed)
    );

    // An empty or inverted window leaves no pixel inside
    assign in_window = (x_d1 >= cfg.hstart) && (x_d1 < cfg.hstop);

    // Output register: border outside the window or while composition is off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_data <= '0;
        end else if (!cfg.enable || !in_window) begin
            display_data <= COLOR_W'(cfg.border);
        end else begin
            display_data <= mixed;
        end
    end

endmodule
